// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART_TX serializer
// between NUM_REQ byte producers.
//
// One byte is accepted per grant over a valid/ready handshake. The byte is
// sent to UART_TX with a one-cycle start strobe. The block then waits for the
// frame-done pulse, or gives up after TIMEOUT_CLKS. An idle guard gap of
// GAP_CLKS follows before the next grant.
//
// Ports
//   Clock       in   system clock, rising edge
//   Reset       in   asynchronous active-high reset
//   Req_Valid   in   [NUM_REQ]   per-requester byte available
//   Req_Data    in   [8*NUM_REQ] byte i on bits [8i+7:8i]
//   Req_Ready   out  [NUM_REQ]   one-hot, one-cycle accept pulse
//   TX_Start    out  one-cycle start strobe to UART_TX
//   TX_Bytes    out  [8] byte to UART_TX; held until back in IDLE
//   TX_Active   in   UART_TX busy (status only, not used for sequencing)
//   TX_Done     in   UART_TX frame-complete pulse
//   Busy        out  high in any state other than IDLE
//   Grant_Id    out  [ID_W] current / most recent granted requester
//   Timeout_Err out  one-cycle pulse when the frame timeout expires
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_CLKS     = 868,
  parameter int TIMEOUT_CLKS = 12*CLKS_PER_BIT
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   Req_Valid,
  input  logic [8*NUM_REQ-1:0] Req_Data,
  output logic [NUM_REQ-1:0]   Req_Ready,
  output logic                 TX_Start,
  output logic [7:0]           TX_Bytes,
  input  logic                 TX_Active,
  input  logic                 TX_Done,
  output logic                 Busy,
  output logic [ID_W-1:0]      Grant_Id,
  output logic                 Timeout_Err
);

  localparam int MAXC  = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
  // GAP_CLKS of 0 or 1 both spend a single cycle in GAP.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CLKS == 0) ? 0 : GAP_CLKS - 1);

  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_DONE, GAP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ID_W-1:0]    last_grant, last_n;
  logic [NUM_REQ-1:0] ready_n;
  logic               start_n, busy_n, terr_n;
  logic [7:0]         bytes_n;
  logic [ID_W-1:0]    grant_n;

  // Round-robin pick. "hi" is the lowest valid index above last_grant.
  // "lo" is the lowest valid index overall, which is the wrap-around choice.
  logic            any_vld, hi_found;
  logic [ID_W-1:0] hi_win, lo_win, win;
  logic [7:0]      win_byte;

  always_comb begin
    any_vld  = 1'b0;
    hi_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (Req_Valid[i]) begin
        any_vld = 1'b1;
        lo_win  = ID_W'(i);
        if (ID_W'(i) > last_grant) begin
          hi_found = 1'b1;
          hi_win   = ID_W'(i);
        end
      end
    end
    win = hi_found ? hi_win : lo_win;
    win_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++)
      if (ID_W'(i) == win) win_byte = Req_Data[8*i +: 8];
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last_grant;
    ready_n = '0;
    start_n = 1'b0;
    terr_n  = 1'b0;
    bytes_n = TX_Bytes;
    grant_n = Grant_Id;
    unique case (state)
      IDLE: begin
        if (any_vld) begin
          bytes_n = win_byte;
          grant_n = win;
          last_n  = win;
          ready_n = NUM_REQ'(1) << win;
          state_n = GRANT;
        end
      end
      GRANT: begin
        start_n = 1'b1;
        state_n = START;
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        // The error is raised on the edge where the counter reaches
        // TIMEOUT_CLKS-1. The pulse therefore lands TIMEOUT_CLKS cycles
        // after the start strobe. A TX_Done on that same edge takes priority.
        cnt_n = cnt + 1'b1;
        if (TX_Done) begin
          cnt_n   = '0;
          state_n = GAP;
        end else if (cnt + 1'b1 == TO_LAST) begin
          cnt_n   = '0;
          terr_n  = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      Req_Ready   <= '0;
      TX_Start    <= 1'b0;
      TX_Bytes    <= 8'h00;
      Busy        <= 1'b0;
      Grant_Id    <= '0;
      Timeout_Err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_grant  <= last_n;
      Req_Ready   <= ready_n;
      TX_Start    <= start_n;
      TX_Bytes    <= bytes_n;
      Busy        <= busy_n;
      Grant_Id    <= grant_n;
      Timeout_Err <= terr_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. A behavioural UART_TX stub logs each
// byte it is started with. It answers with TX_Done FRAME clocks later.
module tb_uart_tx_arbiter;
  localparam int CPB   = 4;
  localparam int GAP   = 3;
  localparam int TO    = 12*CPB;
  localparam int FRAME = 10*CPB;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Req_Valid = '0;
  logic [31:0] Req_Data = '0;
  logic [3:0]  Req_Ready;
  logic        TX_Start;
  logic [7:0]  TX_Bytes;
  logic        TX_Active = 1'b0;
  logic        TX_Done;
  logic        Busy;
  logic [1:0]  Grant_Id;
  logic        Timeout_Err;

  logic stub_done = 1'b0, inj_done = 1'b0, done_en = 1'b1;
  assign TX_Done = stub_done | inj_done;

  int checks = 0, errors = 0;
  int cyc = 0, fcnt = 0, n_to = 0, to_cyc = 0, start_cyc = 0, n_start = 0;
  logic [7:0] rx_q[$];
  logic [1:0] gnt_q[$];

  uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .CLKS_PER_BIT(CPB), .GAP_CLKS(GAP),
                    .TIMEOUT_CLKS(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Req_Valid(Req_Valid), .Req_Data(Req_Data),
    .Req_Ready(Req_Ready), .TX_Start(TX_Start), .TX_Bytes(TX_Bytes),
    .TX_Active(TX_Active), .TX_Done(TX_Done), .Busy(Busy), .Grant_Id(Grant_Id),
    .Timeout_Err(Timeout_Err));

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // UART_TX stub plus monitors, all sampled mid-cycle.
  always @(negedge Clock) begin
    stub_done <= 1'b0;
    if (Reset) begin
      fcnt <= 0;
      TX_Active <= 1'b0;
    end else if (TX_Start) begin
      rx_q.push_back(TX_Bytes);
      start_cyc <= cyc;
      n_start <= n_start + 1;
      fcnt <= FRAME;
      TX_Active <= 1'b1;
    end else if (fcnt > 0) begin
      fcnt <= fcnt - 1;
      if (fcnt == 1) begin
        TX_Active <= 1'b0;
        if (done_en) stub_done <= 1'b1;
      end
    end
    if (Req_Ready != 4'b0000) gnt_q.push_back(Grant_Id);
    if (Timeout_Err) begin
      n_to <= n_to + 1;
      to_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({Req_Ready, TX_Start, TX_Bytes, Busy, Grant_Id, Timeout_Err} !== 17'h0) begin
      errors++;
      $display("FAIL reset_vals got rdy=%b st=%b by=%h busy=%b gid=%0d terr=%b want all 0",
               Req_Ready, TX_Start, TX_Bytes, Busy, Grant_Id, Timeout_Err);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] eg [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] eb [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    int n;
    gnt_q.delete(); rx_q.delete();
    Req_Data = {8'h43, 8'h32, 8'h21, 8'h10};
    Req_Valid = 4'b1111;
    n = 0;
    while (gnt_q.size() < 5 && n < 2000) begin tick(); n++; end
    Req_Valid = 4'b0000;
    n = 0;
    while (Busy && n < 200) begin tick(); n++; end
    checks++;
    if (gnt_q.size() != 5 || rx_q.size() != 5) begin
      errors++;
      $display("FAIL rr_count got grants=%0d bytes=%0d want 5/5", gnt_q.size(), rx_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < gnt_q.size()) begin
        checks++;
        if (gnt_q[i] !== eg[i]) begin
          errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, gnt_q[i], eg[i]);
        end
      end
      if (i < rx_q.size()) begin
        checks++;
        if (rx_q[i] !== eb[i]) begin
          errors++; $display("FAIL rr_byte[%0d] got %h want %h", i, rx_q[i], eb[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    int n;
    rx_q.delete();
    Req_Data = {8'h00, 8'hA5, 8'h00, 8'h00};
    Req_Valid = 4'b0100;
    tick();
    checks++;
    if (Req_Ready !== 4'b0100 || Grant_Id !== 2'd2 || TX_Bytes !== 8'hA5 ||
        TX_Start !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got rdy=%b gid=%0d by=%h st=%b busy=%b want 0100/2/a5/0/1",
               Req_Ready, Grant_Id, TX_Bytes, TX_Start, Busy);
    end
    tick();
    Req_Valid = 4'b0000;
    checks++;
    if (Req_Ready !== 4'b0000 || TX_Start !== 1'b1) begin
      errors++; $display("FAIL single_start got rdy=%b st=%b want 0000/1", Req_Ready, TX_Start);
    end
    tick();
    checks++;
    if (TX_Start !== 1'b0 || Busy !== 1'b1 || TX_Bytes !== 8'hA5) begin
      errors++; $display("FAIL single_wait got st=%b busy=%b by=%h want 0/1/a5", TX_Start, Busy, TX_Bytes);
    end
    n = 0;
    while (TX_Done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (TX_Done !== 1'b1) begin errors++; $display("FAIL single_done got none want TX_Done"); end
    n = 0;
    while (Busy && n < 20) begin tick(); n++; end
    checks++;
    if (n != GAP) begin errors++; $display("FAIL single_gap got %0d want %0d", n, GAP); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || n_to != 0) begin
      errors++; $display("FAIL single_rx got n=%0d to=%0d want one a5, no timeout", rx_q.size(), n_to);
    end
  endtask

  task automatic test_priority();
    logic [1:0] eg [4] = '{2'd1, 2'd3, 2'd0, 2'd1};
    int n;
    gnt_q.delete();
    Req_Data = {8'h73, 8'h00, 8'h51, 8'h04};
    Req_Valid = 4'b0010;
    n = 0; while (gnt_q.size() < 1 && n < 300) begin tick(); n++; end
    Req_Valid = 4'b1010;
    n = 0; while (gnt_q.size() < 2 && n < 300) begin tick(); n++; end
    tick(); tick(); tick();
    Req_Valid = 4'b0011;
    n = 0; while (gnt_q.size() < 3 && n < 300) begin tick(); n++; end
    Req_Valid = 4'b0010;
    n = 0; while (gnt_q.size() < 4 && n < 300) begin tick(); n++; end
    Req_Valid = 4'b0000;
    n = 0; while (Busy && n < 200) begin tick(); n++; end
    checks++;
    if (gnt_q.size() != 4) begin
      errors++; $display("FAIL prio_count got %0d want 4", gnt_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_q.size()) begin
        checks++;
        if (gnt_q[i] !== eg[i]) begin
          errors++; $display("FAIL prio_grant[%0d] got %0d want %0d", i, gnt_q[i], eg[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    gnt_q.delete(); rx_q.delete();
    done_en = 1'b0;
    Req_Data = {8'h3C, 8'h00, 8'h00, 8'hC3};
    Req_Valid = 4'b0001;
    n = 0; while (gnt_q.size() < 1 && n < 300) begin tick(); n++; end
    Req_Valid = 4'b0000;
    n = 0; while (n_to < 1 && n < 200) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (n_to != 1) begin errors++; $display("FAIL timeout_count got %0d want 1", n_to); end
    checks++;
    if (to_cyc - start_cyc != TO) begin
      errors++; $display("FAIL timeout_delay got %0d want %0d", to_cyc - start_cyc, TO);
    end
    done_en = 1'b1;
    Req_Valid = 4'b1000;
    n = 0; while (gnt_q.size() < 2 && n < 300) begin tick(); n++; end
    Req_Valid = 4'b0000;
    n = 0; while (Busy && n < 200) begin tick(); n++; end
    checks++;
    if (gnt_q.size() != 2 || rx_q.size() != 2 || n_to != 1) begin
      errors++; $display("FAIL timeout_next got grants=%0d bytes=%0d to=%0d want 2/2/1",
                         gnt_q.size(), rx_q.size(), n_to);
    end else begin
      checks++;
      if (gnt_q[1] !== 2'd3 || rx_q[1] !== 8'h3C) begin
        errors++; $display("FAIL timeout_next_val got gid=%0d by=%h want 3/3c", gnt_q[1], rx_q[1]);
      end
    end
  endtask

  task automatic test_coincide();
    int n, to0, st0;
    gnt_q.delete();
    to0 = n_to; st0 = n_start;
    done_en = 1'b0;
    Req_Data = {8'h00, 8'h5A, 8'h00, 8'h00};
    Req_Valid = 4'b0100;
    n = 0; while (gnt_q.size() < 1 && n < 300) begin tick(); n++; end
    Req_Valid = 4'b0000;
    n = 0; while (n_start == st0 && n < 20) begin tick(); n++; end
    n = 0; while (cyc != start_cyc + TO - 1 && n < 200) begin tick(); n++; end
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    checks++;
    if (Timeout_Err !== 1'b0 || Busy !== 1'b1) begin
      errors++; $display("FAIL coincide_edge got terr=%b busy=%b want 0/1", Timeout_Err, Busy);
    end
    n = 0; while (Busy && n < 20) begin tick(); n++; end
    checks++;
    if (n != GAP || n_to != to0 || n_start != st0 + 1) begin
      errors++; $display("FAIL coincide_after got gap=%0d to=%0d starts=%0d want %0d/%0d/%0d",
                         n, n_to - to0, n_start - st0, GAP, 0, 1);
    end
    done_en = 1'b1;
  endtask

  task automatic test_done_ignored();
    int n, to0, st0;
    to0 = n_to; st0 = n_start;
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    tick();
    checks++;
    if (Busy !== 1'b0 || TX_Start !== 1'b0 || Req_Ready !== 4'b0000) begin
      errors++; $display("FAIL idle_done got busy=%b st=%b rdy=%b want 0/0/0000", Busy, TX_Start, Req_Ready);
    end
    gnt_q.delete();
    Req_Valid = 4'b0001;
    n = 0; while (gnt_q.size() < 1 && n < 300) begin tick(); n++; end
    Req_Valid = 4'b0000;
    n = 0; while (TX_Done !== 1'b1 && n < 100) begin tick(); n++; end
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    n = 1; while (Busy && n < 20) begin tick(); n++; end
    checks++;
    if (n != GAP || n_to != to0 || n_start != st0 + 1) begin
      errors++; $display("FAIL gap_done got gap=%0d to=%0d starts=%0d want %0d/%0d/%0d",
                         n, n_to - to0, n_start - st0, GAP, 0, 1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    gnt_q.delete();
    Req_Data = {8'h00, 8'h77, 8'h00, 8'h00};
    Req_Valid = 4'b0100;
    n = 0; while (gnt_q.size() < 1 && n < 300) begin tick(); n++; end
    Req_Valid = 4'b0000;
    for (int i = 0; i < 10; i++) tick();
    Reset = 1'b1;
    #1;
    checks++;
    if (TX_Start !== 1'b0 || Busy !== 1'b0 || Req_Ready !== 4'b0000 ||
        Grant_Id !== 2'd0 || TX_Bytes !== 8'h00) begin
      errors++; $display("FAIL reset_mid got st=%b busy=%b rdy=%b gid=%0d by=%h want 0/0/0000/0/00",
                         TX_Start, Busy, Req_Ready, Grant_Id, TX_Bytes);
    end
    tick(); tick(); tick();
    Reset = 1'b0;
    tick();
    Req_Data = {8'h44, 8'h33, 8'h22, 8'h11};
    Req_Valid = 4'b1111;
    tick();
    checks++;
    if (Req_Ready !== 4'b0001 || Grant_Id !== 2'd0 || TX_Bytes !== 8'h11) begin
      errors++; $display("FAIL reset_regrant got rdy=%b gid=%0d by=%h want 0001/0/11",
                         Req_Ready, Grant_Id, TX_Bytes);
    end
    tick();
    Req_Valid = 4'b0000;
    n = 0; while (Busy && n < 200) begin tick(); n++; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_priority();
    test_timeout();
    test_coincide();
    test_done_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
